l2_mem_sched: RTL and testbench

Single-owner scheduler for the L2 local memory array (tag/state/hprot/line SRAMs plus evict-way table).
- Shares the single-ported array between NUM_REQ requesters (e.g. core-request and forward/response pipelines) with round-robin arbitration.
- Runs the post-reset invalidation sweep and an on-demand flush sweep.
- Sits between the L2 FSMs and the local memory. It drives all memory control strobes plus set/way, and issues a one-hot select the top level uses to mux write data.

---
 rtl/l2_sched_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/l2_mem_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_l2_mem_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_sched_pkg.sv
// ============================================================================
//  Module   : l2_sched_pkg
//  Purpose  : Shared types and constants for the L2 local-memory scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package l2_sched_pkg;

  // Largest requester count the scheduler (and its 2-bit ids) supports
  localparam int MAX_REQ      = 4;

  // Default geometry of the L2 local memory
  localparam int DEF_SET_BITS = 9;
  localparam int DEF_WAY_BITS = 3;
  localparam int L2_SETS      = 1 << DEF_SET_BITS;
  localparam int L2_WAYS      = 1 << DEF_WAY_BITS;

  // Access kind requested by an L2 pipeline
  typedef enum logic [2:0] {
    OP_RD       = 3'd0,
    OP_WR_LINE  = 3'd1,
    OP_WR_STATE = 3'd2,
    OP_WR_EVICT = 3'd3,
    OP_WR_PUT   = 3'd4
  } mem_op_t;

  // Scheduler top-level state
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter; search starts at the pointer, which moves
//             past the winner only when the grant is consumed (i_advance).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [1:0]         o_idx,
  output logic               o_any
);

  logic [1:0] r_ptr;

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(r_ptr) + k) % NUM_REQ;
      if (!o_any && i_valid[j]) begin
        o_any      = 1'b1;
        o_idx      = 2'(j);
        o_grant[j] = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1 only on a consumed grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_any) begin
      r_ptr <= (o_idx == 2'(NUM_REQ - 1)) ? 2'd0 : o_idx + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_mem_sched.sv
// ============================================================================
//  Module   : l2_mem_sched
//  Purpose  : Single owner of the L2 local memory: reset invalidation sweep,
//             round-robin access arbitration and on-demand flush sweep.
//             Optional macro L2_SCHED_PERF_EN adds grant/stall counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module l2_mem_sched
  import l2_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int SET_BITS = 9,
  parameter int WAY_BITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*3-1:0]         i_req_op,
  input  logic [NUM_REQ*SET_BITS-1:0]  i_req_set,
  input  logic [NUM_REQ*WAY_BITS-1:0]  i_req_way,
  output logic                         o_mem_rd_en,
  output logic                         o_mem_wr_en_line,
  output logic                         o_mem_wr_en_state,
  output logic                         o_mem_wr_en_evict_way,
  output logic                         o_mem_wr_en_put_reqs,
  output logic                         o_mem_wr_rst,
  output logic [SET_BITS-1:0]          o_mem_set,
  output logic [WAY_BITS-1:0]          o_mem_way,
  output logic [NUM_REQ-1:0]           o_mem_sel,
  output logic                         o_rsp_valid,
  output logic [1:0]                   o_rsp_id,
  input  logic                         i_flush_start,
  input  logic                         i_flush_ready,
  output logic                         o_flush_rsp_valid,
  output logic [SET_BITS-1:0]          o_flush_set,
  output logic [WAY_BITS-1:0]          o_flush_way,
  output logic                         o_flush_done,
  output logic                         o_init_done
`ifdef L2_SCHED_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]        o_perf_grants,
  output logic [31:0]                  o_perf_stall
`endif
);

  localparam logic [SET_BITS-1:0] C_SET_LAST = {SET_BITS{1'b1}};
  localparam logic [WAY_BITS-1:0] C_WAY_LAST = {WAY_BITS{1'b1}};
  localparam logic [SET_BITS-1:0] C_SET_ONE  = SET_BITS'(1);
  localparam logic [WAY_BITS-1:0] C_WAY_ONE  = WAY_BITS'(1);

  sched_state_t        r_state, w_state_nxt;
  logic [SET_BITS-1:0] r_set_cnt, w_set_nxt;
  logic [WAY_BITS-1:0] r_way_cnt, w_way_nxt;
  logic                r_init_done, w_init_done_nxt;
  logic                r_flush_end, w_flush_end_nxt;
  logic                r_flush_done, w_flush_done_nxt;
  logic                w_flush_issue, w_rd_fire;
  logic                r_rsp_valid, r_flush_rsp_valid;
  logic [1:0]          r_rsp_id;
  logic [SET_BITS-1:0] r_flush_set;
  logic [WAY_BITS-1:0] r_flush_way;

  logic [NUM_REQ-1:0]  w_grant;
  logic [1:0]          w_gidx;
  logic                w_any;
  logic                w_advance;

  mem_op_t             w_op_arr  [MAX_REQ];
  logic [SET_BITS-1:0] w_set_arr [MAX_REQ];
  logic [WAY_BITS-1:0] w_way_arr [MAX_REQ];

  // Unpack per-requester fields; unused slots read as zero
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
    if (i < NUM_REQ) begin : g_used
      assign w_op_arr[i]  = mem_op_t'(i_req_op[3*i +: 3]);
      assign w_set_arr[i] = i_req_set[SET_BITS*i +: SET_BITS];
      assign w_way_arr[i] = i_req_way[WAY_BITS*i +: WAY_BITS];
    end else begin : g_unused
      assign w_op_arr[i]  = OP_RD;
      assign w_set_arr[i] = '0;
      assign w_way_arr[i] = '0;
    end
  end

  assign w_advance = (r_state == ST_IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_req_valid),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_idx     (w_gidx),
    .o_any     (w_any)
  );

  // Next-state and memory-control decode; sweep strobes are gated by rst so
  // every output reads zero while reset is held
  always_comb begin
    w_state_nxt           = r_state;
    w_set_nxt             = r_set_cnt;
    w_way_nxt             = r_way_cnt;
    w_init_done_nxt       = r_init_done;
    w_flush_end_nxt       = r_flush_end;
    w_flush_done_nxt      = 1'b0;
    w_flush_issue         = 1'b0;
    w_rd_fire             = 1'b0;
    o_req_ready           = '0;
    o_mem_rd_en           = 1'b0;
    o_mem_wr_en_line      = 1'b0;
    o_mem_wr_en_state     = 1'b0;
    o_mem_wr_en_evict_way = 1'b0;
    o_mem_wr_en_put_reqs  = 1'b0;
    o_mem_wr_rst          = 1'b0;
    o_mem_set             = '0;
    o_mem_way             = '0;
    o_mem_sel             = '0;
    unique case (r_state)
      ST_INIT: begin
        o_mem_rd_en  = rst;
        o_mem_wr_rst = rst;
        o_mem_set    = r_set_cnt;
        w_set_nxt    = r_set_cnt + C_SET_ONE;
        if (r_set_cnt == C_SET_LAST) begin
          w_state_nxt     = ST_IDLE;
          w_init_done_nxt = 1'b1;
        end
      end
      ST_IDLE: begin
        if (w_any) begin
          o_req_ready = w_grant;
          o_mem_rd_en = 1'b1;
          o_mem_set   = w_set_arr[w_gidx];
          o_mem_way   = w_way_arr[w_gidx];
          o_mem_sel   = w_grant;
          case (w_op_arr[w_gidx])
            OP_RD:       w_rd_fire             = 1'b1;
            OP_WR_LINE:  o_mem_wr_en_line      = 1'b1;
            OP_WR_STATE: o_mem_wr_en_state     = 1'b1;
            OP_WR_EVICT: o_mem_wr_en_evict_way = 1'b1;
            OP_WR_PUT:   o_mem_wr_en_put_reqs  = 1'b1;
            default:     ;
          endcase
        end
        if (i_flush_start) begin
          w_state_nxt     = ST_FLUSH;
          w_set_nxt       = '0;
          w_way_nxt       = '0;
          w_flush_end_nxt = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (r_flush_end) begin
          // final response is on the bus this cycle; finish next cycle
          w_state_nxt      = ST_IDLE;
          w_flush_end_nxt  = 1'b0;
          w_flush_done_nxt = 1'b1;
        end else if (i_flush_ready) begin
          w_flush_issue = 1'b1;
          o_mem_rd_en   = 1'b1;
          o_mem_set     = r_set_cnt;
          o_mem_way     = r_way_cnt;
          w_way_nxt     = r_way_cnt + C_WAY_ONE;
          if (r_way_cnt == C_WAY_LAST) begin
            w_set_nxt = r_set_cnt + C_SET_ONE;
            if (r_set_cnt == C_SET_LAST) w_flush_end_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State, counters and one-cycle-delayed response tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= ST_INIT;
      r_set_cnt         <= '0;
      r_way_cnt         <= '0;
      r_init_done       <= 1'b0;
      r_flush_end       <= 1'b0;
      r_flush_done      <= 1'b0;
      r_rsp_valid       <= 1'b0;
      r_rsp_id          <= '0;
      r_flush_rsp_valid <= 1'b0;
      r_flush_set       <= '0;
      r_flush_way       <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_set_cnt         <= w_set_nxt;
      r_way_cnt         <= w_way_nxt;
      r_init_done       <= w_init_done_nxt;
      r_flush_end       <= w_flush_end_nxt;
      r_flush_done      <= w_flush_done_nxt;
      r_rsp_valid       <= w_rd_fire;
      r_flush_rsp_valid <= w_flush_issue;
      if (w_rd_fire) r_rsp_id <= w_gidx;
      if (w_flush_issue) begin
        r_flush_set <= r_set_cnt;
        r_flush_way <= r_way_cnt;
      end
    end
  end

  assign o_rsp_valid       = r_rsp_valid;
  assign o_rsp_id          = r_rsp_id;
  assign o_flush_rsp_valid = r_flush_rsp_valid;
  assign o_flush_set       = r_flush_set;
  assign o_flush_way       = r_flush_way;
  assign o_flush_done      = r_flush_done;
  assign o_init_done       = r_init_done;

`ifdef L2_SCHED_PERF_EN
  logic [31:0] r_perf_stall;
  logic        w_granted;

  assign w_granted = (r_state == ST_IDLE) && w_any;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    logic [31:0] r_cnt;
    // Saturating count of grants to requester i
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     r_cnt <= '0;
      else if (w_granted && w_grant[i] && ~&r_cnt)  r_cnt <= r_cnt + 32'd1;
    end
    assign o_perf_grants[32*i +: 32] = r_cnt;
  end

  // Saturating count of cycles where someone waits and nobody is granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               r_perf_stall <= '0;
    else if (|i_req_valid && !w_granted && ~&r_perf_stall)  r_perf_stall <= r_perf_stall + 32'd1;
  end
  assign o_perf_stall = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_sched.sv
// ============================================================================
//  Module   : tb_l2_mem_sched
//  Purpose  : Self-checking bench for l2_mem_sched: reset sweep, arbitration
//             vector table, flush sweep and reset during flush.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l2_mem_sched;
  import l2_sched_pkg::*;

  localparam int NR = 2;
  localparam int SB = 9;
  localparam int WB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] i_req_valid = '0;
  mem_op_t       op0 = OP_RD, op1 = OP_RD;
  logic [SB-1:0] set0 = '0, set1 = '0;
  logic [WB-1:0] way0 = '0, way1 = '0;
  logic          i_flush_start = 1'b0, i_flush_ready = 1'b0;

  logic [NR-1:0] o_req_ready, o_mem_sel;
  logic          o_mem_rd_en, o_mem_wr_en_line, o_mem_wr_en_state;
  logic          o_mem_wr_en_evict_way, o_mem_wr_en_put_reqs, o_mem_wr_rst;
  logic [SB-1:0] o_mem_set, o_flush_set;
  logic [WB-1:0] o_mem_way, o_flush_way;
  logic          o_rsp_valid, o_flush_rsp_valid, o_flush_done, o_init_done;
  logic [1:0]    o_rsp_id;

  l2_mem_sched #(.NUM_REQ(NR), .SET_BITS(SB), .WAY_BITS(WB)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_req_valid           (i_req_valid),
    .o_req_ready           (o_req_ready),
    .i_req_op              ({op1, op0}),
    .i_req_set             ({set1, set0}),
    .i_req_way             ({way1, way0}),
    .o_mem_rd_en           (o_mem_rd_en),
    .o_mem_wr_en_line      (o_mem_wr_en_line),
    .o_mem_wr_en_state     (o_mem_wr_en_state),
    .o_mem_wr_en_evict_way (o_mem_wr_en_evict_way),
    .o_mem_wr_en_put_reqs  (o_mem_wr_en_put_reqs),
    .o_mem_wr_rst          (o_mem_wr_rst),
    .o_mem_set             (o_mem_set),
    .o_mem_way             (o_mem_way),
    .o_mem_sel             (o_mem_sel),
    .o_rsp_valid           (o_rsp_valid),
    .o_rsp_id              (o_rsp_id),
    .i_flush_start         (i_flush_start),
    .i_flush_ready         (i_flush_ready),
    .o_flush_rsp_valid     (o_flush_rsp_valid),
    .o_flush_set           (o_flush_set),
    .o_flush_way           (o_flush_way),
    .o_flush_done          (o_flush_done),
    .o_init_done           (o_init_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0]  rq[$];   // expected rsp ids
  logic [11:0] fq[$];   // expected flush {set,way}

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic check_rsp();
    logic [2:0] e;
    e = 3'b0;
    if (rq.size() > 0) e = {1'b1, rq.pop_front()};
    chk("rsp", {61'd0, o_rsp_valid, (o_rsp_valid ? o_rsp_id : 2'b00)}, {61'd0, e});
  endtask

  task automatic check_frsp();
    logic [12:0] e;
    e = 13'b0;
    if (fq.size() > 0) e = {1'b1, fq.pop_front()};
    chk("flush_rsp", {51'd0, o_flush_rsp_valid,
                      (o_flush_rsp_valid ? {o_flush_set, o_flush_way} : 12'd0)}, {51'd0, e});
  endtask

  // {ready, rd_en, line, state, evict, put, wr_rst, set, way, sel}; address masked when idle
  function automatic logic [21:0] mem_outs();
    return {o_req_ready, o_mem_rd_en, o_mem_wr_en_line, o_mem_wr_en_state,
            o_mem_wr_en_evict_way, o_mem_wr_en_put_reqs, o_mem_wr_rst,
            (o_mem_rd_en ? o_mem_set : 9'd0), (o_mem_rd_en ? o_mem_way : 3'd0),
            (o_mem_rd_en ? o_mem_sel : 2'b00)};
  endfunction

  function automatic logic [31:0] all_outs();
    return {o_req_ready, o_mem_sel, o_mem_rd_en, o_mem_wr_en_line, o_mem_wr_en_state,
            o_mem_wr_en_evict_way, o_mem_wr_en_put_reqs, o_mem_wr_rst, o_mem_set,
            o_mem_way, o_rsp_valid, o_rsp_id, o_flush_rsp_valid, o_flush_done, o_init_done};
  endfunction

  // Release reset has just happened; check the 512-cycle invalidation sweep
  task automatic run_sweep();
    i_req_valid   = 2'b11;
    i_flush_start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 500) i_flush_start = 1'b0;
      check_rsp();
      chk("sweep", {45'd0, o_req_ready, o_mem_rd_en, o_mem_wr_rst, o_mem_wr_en_line,
                    o_mem_wr_en_state, o_mem_wr_en_evict_way, o_mem_wr_en_put_reqs,
                    o_mem_set, o_init_done, o_flush_done, o_flush_rsp_valid},
                   {45'd0, 2'b00, 1'b1, 1'b1, 4'b0000, 9'(i), 3'b000});
    end
    i_req_valid = 2'b10;
    op1 = OP_RD; set1 = 9'd77; way1 = 3'd5;
    @(negedge clk);
    check_rsp();
    chk("init_exit", {35'd0, o_init_done, mem_outs(), o_flush_done},
                     {35'd0, 1'b1, 2'b10, 1'b1, 5'b00000, 9'd77, 3'd5, 2'b10, 1'b0});
    rq.push_back(2'd1);
  endtask

  typedef struct {
    logic [1:0] valid;
    mem_op_t    op0, op1;
    logic [8:0] s0, s1;
    logic [2:0] w0, w1;
    logic [1:0] ready;
    logic [4:0] strb;  // line, state, evict, put, wr_rst
    logic       rd;
    logic [8:0] set;
    logic [2:0] way;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int issued, tail;
    bit fin;

    tbl[0]  = '{2'b11, OP_RD,       OP_RD,       9'd10,  9'd20, 3'd1, 3'd2, 2'b01, 5'b00000, 1'b1, 9'd10,  3'd1};
    tbl[1]  = '{2'b11, OP_RD,       OP_RD,       9'd10,  9'd20, 3'd1, 3'd2, 2'b10, 5'b00000, 1'b1, 9'd20,  3'd2};
    tbl[2]  = '{2'b11, OP_RD,       OP_RD,       9'd10,  9'd20, 3'd1, 3'd2, 2'b01, 5'b00000, 1'b1, 9'd10,  3'd1};
    tbl[3]  = '{2'b11, OP_RD,       OP_RD,       9'd10,  9'd20, 3'd1, 3'd2, 2'b10, 5'b00000, 1'b1, 9'd20,  3'd2};
    tbl[4]  = '{2'b10, OP_RD,       OP_WR_PUT,   9'd0,   9'd5,  3'd0, 3'd3, 2'b10, 5'b00010, 1'b1, 9'd5,   3'd3};
    tbl[5]  = '{2'b00, OP_WR_LINE,  OP_WR_LINE,  9'd1,   9'd2,  3'd1, 3'd2, 2'b00, 5'b00000, 1'b0, 9'd0,   3'd0};
    tbl[6]  = '{2'b01, OP_WR_LINE,  OP_RD,       9'd511, 9'd0,  3'd7, 3'd0, 2'b01, 5'b10000, 1'b1, 9'd511, 3'd7};
    tbl[7]  = '{2'b01, OP_WR_STATE, OP_RD,       9'd0,   9'd0,  3'd0, 3'd0, 2'b01, 5'b01000, 1'b1, 9'd0,   3'd0};
    tbl[8]  = '{2'b11, OP_WR_EVICT, OP_WR_STATE, 9'd3,   9'd6,  3'd4, 3'd5, 2'b10, 5'b01000, 1'b1, 9'd6,   3'd5};
    tbl[9]  = '{2'b11, OP_WR_EVICT, OP_WR_STATE, 9'd3,   9'd6,  3'd4, 3'd5, 2'b01, 5'b00100, 1'b1, 9'd3,   3'd4};
    tbl[10] = '{2'b10, OP_WR_LINE,  OP_RD,       9'd0,   9'd100,3'd0, 3'd6, 2'b10, 5'b00000, 1'b1, 9'd100, 3'd6};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("reset_outs", {32'd0, all_outs()}, 64'd0);

    // ---- post-reset sweep ----
    rst = 1'b1;
    #1;
    run_sweep();

    // ---- arbitration / op decode table ----
    foreach (tbl[v]) begin
      @(posedge clk); #1;
      i_req_valid = tbl[v].valid;
      op0 = tbl[v].op0; op1 = tbl[v].op1;
      set0 = tbl[v].s0; set1 = tbl[v].s1;
      way0 = tbl[v].w0; way1 = tbl[v].w1;
      @(negedge clk);
      check_rsp();
      chk($sformatf("vec%0d", v), {42'd0, mem_outs()},
          {42'd0, tbl[v].ready, tbl[v].rd, tbl[v].strb, tbl[v].set, tbl[v].way, tbl[v].ready});
      if (tbl[v].ready != 2'b00 && (tbl[v].ready[1] ? tbl[v].op1 : tbl[v].op0) == OP_RD)
        rq.push_back(tbl[v].ready[1] ? 2'd1 : 2'd0);
    end

    // ---- flush_start in the same cycle as a req0 grant ----
    @(posedge clk); #1;
    i_req_valid = 2'b01; op0 = OP_RD; set0 = 9'd7; way0 = 3'd2; i_flush_start = 1'b1;
    @(negedge clk);
    check_rsp();
    chk("flush_start_grant", {42'd0, mem_outs()},
        {42'd0, 2'b01, 1'b1, 5'b00000, 9'd7, 3'd2, 2'b01});
    rq.push_back(2'd0);

    // ---- flush sweep with flush_ready toggling 1,0 ----
    op0 = OP_RD; op1 = OP_RD; set0 = 9'd30; set1 = 9'd40; way0 = 3'd3; way1 = 3'd4;
    issued = 0; tail = -1; fin = 1'b0;
    for (int c = 0; c < 9000 && !fin; c++) begin
      @(posedge clk); #1;
      i_flush_ready = (c % 2 == 0);
      i_flush_start = (c == 7 || c == 100);
      i_req_valid   = 2'b11;
      @(negedge clk);
      check_rsp();
      check_frsp();
      if (c == tail) begin
        chk("flush_exit", {41'd0, mem_outs(), o_flush_done},
            {41'd0, 2'b10, 1'b1, 5'b00000, 9'd40, 3'd4, 2'b10, 1'b1});
        rq.push_back(2'd1);
        fin = 1'b1;
      end else if (issued < 4096 && i_flush_ready) begin
        chk("flush_issue", {41'd0, mem_outs(), o_flush_done},
            {41'd0, 2'b00, 1'b1, 5'b00000, 9'(issued >> 3), 3'(issued & 7), 2'b00, 1'b0});
        fq.push_back({9'(issued >> 3), 3'(issued & 7)});
        issued++;
        if (issued == 4096) tail = c + 2;
      end else begin
        chk("flush_stall", {41'd0, mem_outs(), o_flush_done}, 64'd0);
      end
    end
    chk("flush_finished", {63'd0, fin}, 64'd1);

    // IDLE grants resume, flush_done was a single pulse
    @(posedge clk); #1;
    @(negedge clk);
    check_rsp();
    check_frsp();
    chk("post_flush_grant", {41'd0, mem_outs(), o_flush_done},
        {41'd0, 2'b01, 1'b1, 5'b00000, 9'd30, 3'd3, 2'b01, 1'b0});
    rq.push_back(2'd0);

    // ---- reset in the middle of a flush ----
    @(posedge clk); #1;
    i_req_valid = 2'b00; i_flush_start = 1'b1; i_flush_ready = 1'b0;
    @(negedge clk);
    check_rsp();
    @(posedge clk); #1;
    i_flush_start = 1'b0; i_flush_ready = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    @(negedge clk);
    chk("flush_at_100", {51'd0, o_mem_rd_en, o_mem_set, o_mem_way}, {51'd0, 1'b1, 9'd100, 3'd0});
    rst = 1'b0;
    #1;
    chk("midflush_reset_outs", {32'd0, all_outs()}, 64'd0);
    @(negedge clk);
    chk("midflush_reset_hold", {32'd0, all_outs()}, 64'd0);
    rq.delete();
    fq.delete();
    i_flush_ready = 1'b0;
    rst = 1'b1;
    #1;
    run_sweep();
    @(posedge clk); #1;
    i_req_valid = 2'b00;
    @(negedge clk);
    check_rsp();
    chk("no_flush_done", {63'd0, o_flush_done}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
